hazardctl: RTL
==============

# hazardctl

Hazard controller on the consumer side of the ID/EX pipeline register. It reads the load/destination fields that ID/EX presents to EX, together with the source fields of the instruction in IF/ID and branch/jump resolution from the MEM stage. From these it drives the stall, bubble and flush controls back into PC, IF/ID, ID/EX and EX/MEM. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- CWIDTH, 32, width of each event counter
- LUSTALL, 1, load-use stall length in cycles; legal range 1..15

- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- idexmemrd  input  1  ID/EX memrdout: the instruction in EX is a load
- idexrt  input  5  ID/EX rtout: load destination register
- ifidrs  input  5  rs field of the instruction in ID
- ifidrt  input  5  rt field of the instruction in ID
- ifidusers  input  1  instruction in ID reads rs
- ifiduserst  input  1  instruction in ID reads rt
- branchtaken  input  1  conditional branch resolved taken in MEM
- jumpmem  input  1  jump present in MEM
- pcwrite  output  1  PC load enable
- ifidwrite  output  1  IF/ID load enable
- idexbubble  output  1  forces all ID/EX control fields (WB/MEM/EX) to zero on this edge
- flush  output  1  clears IF/ID, ID/EX and EX/MEM control fields on this edge
- busy  output  1  FSM is in STALL
- stallcnt  output  CWIDTH  cycles with pcwrite=0 (saturating)
- flushcnt  output  CWIDTH  cycles with flush=1 (saturating)

## Operation
- Load-use hazard signal `hz` = idexmemrd & (idexrt != 0) & ((ifidusers & idexrt==ifidrs) | (ifiduserst & idexrt==ifidrt)).
- Redirect signal `rd` = branchtaken | jumpmem.
- FSM has two states, IDLE and STALL. It also holds a 4-bit down-counter `rem`.
- Decision in IDLE:
  - `rd`=1: flush=1, pcwrite=1, ifidwrite=1, idexbubble=1. State stays IDLE.
  - `hz`=1 and `rd`=0: pcwrite=0, ifidwrite=0, idexbubble=1, flush=0. If LUSTALL>1, go to STALL with rem=LUSTALL-1. Otherwise stay in IDLE.
  - Neither: pcwrite=1, ifidwrite=1, idexbubble=0, flush=0.
- Decision in STALL:
  - `rd`=1: redirect outputs as in IDLE. Next state is IDLE, rem=0. Redirect has priority in every state.
  - `rd`=0: pcwrite=0, ifidwrite=0, idexbubble=1. `hz` is ignored. rem decrements. When rem==1 at the edge, next state is IDLE.
- busy=1 exactly when state==STALL.
- stallcnt increments on each edge where pcwrite=0 and rst=0. It holds at 2^CWIDTH-1.
- flushcnt increments on each edge where flush=1 and rst=0. It holds at 2^CWIDTH-1.
- Register $0 never causes a hazard.

## Timing
- pcwrite, ifidwrite, idexbubble and flush are combinational from the inputs and the current state. They are valid before the same rising edge that the consuming registers sample.
- A load followed immediately by a dependent instruction gives LUSTALL stall cycles. The dependent instruction enters EX LUSTALL+1 cycles after the load.
- Redirect costs 3 bubbles: IF/ID, ID/EX and EX/MEM are cleared on one edge.
- Simultaneous `hz` and `rd`: redirect wins. stallcnt does not increment; flushcnt increments.
- Reset values while rst=1:
  - State and rem: state=IDLE, rem=0, busy=0.
  - Event counters: stallcnt=0, flushcnt=0.
  - Pipeline controls: pcwrite=0, ifidwrite=0, idexbubble=1, flush=1.
- Counters do not count during reset.
- Reset asserted mid-STALL returns the block to IDLE immediately (asynchronously). After deassertion the block resumes in IDLE with no remaining stall.
- LUSTALL outside 1..15 is illegal and is checked by the bench with an elaboration assertion.

## Test plan
- Reset: assert rst mid-cycle with LUSTALL=3 while in STALL. Required: busy=0, stallcnt=0, flushcnt=0, flush=1, pcwrite=0 immediately. After release, with no hazard: pcwrite=1.
- Load-use on rs, LUSTALL=1: idexmemrd=1, idexrt=5, ifidrs=5, ifidusers=1 for one cycle. Required: pcwrite=0, ifidwrite=0, idexbubble=1 for exactly 1 cycle; stallcnt=1; busy never asserts.
- Multi-cycle stall, LUSTALL=3, hazard on rt=9 held 1 cycle. Required: pcwrite=0 for 3 consecutive cycles, busy=1 for cycles 2-3, stallcnt=3.
- No hazard cases. Required: pcwrite=1, idexbubble=0, stallcnt unchanged for each of:
  - idexrt=0 with ifidrs=0;
  - idexrt=7 with ifidrt=7 but ifiduserst=0;
  - idexmemrd=0.
- Redirect during STALL, LUSTALL=4: branchtaken=1 on the 2nd stall cycle. Required: flush=1, pcwrite=1 that cycle; next cycle state IDLE (busy=0); flushcnt=1, stallcnt=1.
- Saturation with CWIDTH=4: hold jumpmem=1 for 20 cycles. Required: flushcnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazardctl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX and IF/ID fields in, pipeline
// register controls out.
interface hazardctl_if;
   logic       idexmemrd;
   logic [4:0] idexrt;
   logic [4:0] ifidrs;
   logic [4:0] ifidrt;
   logic       ifidusers;
   logic       ifiduserst;
   logic       branchtaken;
   logic       jumpmem;
   logic       pcwrite;
   logic       ifidwrite;
   logic       idexbubble;
   logic       flush;
   logic       busy;

   modport master (
      output idexmemrd, idexrt, ifidrs, ifidrt, ifidusers, ifiduserst, branchtaken, jumpmem,
      input  pcwrite, ifidwrite, idexbubble, flush, busy
   );

   modport slave (
      input  idexmemrd, idexrt, ifidrs, ifidrt, ifidusers, ifiduserst, branchtaken, jumpmem,
      output pcwrite, ifidwrite, idexbubble, flush, busy
   );
endinterface

// File: rtl/hazardctl.sv
// Load-use stall / redirect flush controller with saturating stall and flush event counters.
module hazardctl #(
   parameter int unsigned CWIDTH  = 32,
   parameter int unsigned LUSTALL = 1
) (
   input  logic              clk,
   input  logic              rst,
   hazardctl_if.slave        bus,
   output logic [CWIDTH-1:0] stallcnt,
   output logic [CWIDTH-1:0] flushcnt
);

   typedef enum logic {StIdle, StStall} state_e;

   localparam logic [3:0] RemInit = 4'(LUSTALL - 1);

   state_e     state_q, state_d;
   logic [3:0] rem_q, rem_d;
   logic       hz, rd;

   always_comb begin
      hz = bus.idexmemrd && (bus.idexrt != 5'd0) &&
           ((bus.ifidusers && (bus.idexrt == bus.ifidrs)) ||
            (bus.ifiduserst && (bus.idexrt == bus.ifidrt)));
      rd = bus.branchtaken || bus.jumpmem;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      unique case (state_q)
         StIdle: begin
            // A single-cycle stall is fully covered by the IDLE decision itself.
            if (!rd && hz && (LUSTALL > 1)) begin
               state_d = StStall;
               rem_d   = RemInit;
            end
         end
         StStall: begin
            if (rd) begin
               state_d = StIdle;
               rem_d   = 4'd0;
            end else begin
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            rem_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      bus.busy = (state_q == StStall);
      if (rst) begin
         bus.pcwrite    = 1'b0;
         bus.ifidwrite  = 1'b0;
         bus.idexbubble = 1'b1;
         bus.flush      = 1'b1;
      end else if (rd) begin
         bus.pcwrite    = 1'b1;
         bus.ifidwrite  = 1'b1;
         bus.idexbubble = 1'b1;
         bus.flush      = 1'b1;
      end else if ((state_q == StStall) || hz) begin
         bus.pcwrite    = 1'b0;
         bus.ifidwrite  = 1'b0;
         bus.idexbubble = 1'b1;
         bus.flush      = 1'b0;
      end else begin
         bus.pcwrite    = 1'b1;
         bus.ifidwrite  = 1'b1;
         bus.idexbubble = 1'b0;
         bus.flush      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallcnt <= '0;
         flushcnt <= '0;
      end else begin
         if (!bus.pcwrite && (stallcnt != '1)) stallcnt <= stallcnt + 1'b1;
         if (bus.flush && (flushcnt != '1)) flushcnt <= flushcnt + 1'b1;
      end
   end

endmodule
